arm_regbank: RTL and testbench
==============================

Name: arm_regbank

Overview:
- Responder end of the core's register-access interface. Execution units (branch, data-processing, load/store) issue read and write requests on this interface; arm_regbank serves them.
- Holds the ARM7 general registers with mode banking, plus the CPSR and the per-mode SPSRs.
- Serves one read port, one write port with SPSR-restore, and CPSR/SPSR access ports, all synchronous to the core clock.

Parameters:
RESET_CPSR, 32'h000000D3, CPSR value after reset (SVC mode, I and F set)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
read_en  input  1  sample read_reg this edge
read_reg  input  4  register index R0-R15
read_value  output  32  registered read data
write_en  input  1  write write_value to write_reg this edge
write_reg  input  4  register index
write_value  input  32  write data
write_restore_from_SPSR  input  1  with write_en and write_reg==15: copy current-mode SPSR to CPSR
cpsr_read_en  input  1  sample CPSR this edge
cpsr_read_value  output  32  registered CPSR data
cpsr_write_en  input  1  load CPSR from cpsr_write_value
cpsr_write_value  input  32  new CPSR
spsr_read_en  input  1  sample current-mode SPSR
spsr_read_value  output  32  registered SPSR data
spsr_write_en  input  1  load current-mode SPSR
spsr_write_value  input  32  new SPSR
mode  output  5  CPSR[4:0], combinational

Behaviour:
- Storage:
  - Unbanked R0-R7 and R15.
  - R8-R12: user copy and FIQ copy.
  - R13/R14: one pair each for usr/sys, fiq, irq, svc, abt, und.
  - SPSR: one each for fiq, irq, svc, abt, und.
- Mode decode from CPSR[4:0]:
  - 10000 usr, 10001 fiq, 10010 irq, 10011 svc, 10111 abt, 11011 und, 11111 sys.
  - Any other encoding banks as usr.
- Reset (rst high at an edge): all GPRs, banked registers and SPSRs become 0. CPSR becomes RESET_CPSR. read_value, cpsr_read_value and spsr_read_value become 0. All other inputs are ignored that cycle. Reset asserted mid-sequence discards any in-flight write.
- Read latency 1:
  - At an edge with read_en=1, read_value loads the mode-mapped register.
  - With read_en=0, read_value holds its last value.
  - cpsr_read_value and spsr_read_value follow the same rule.
  - spsr_read in usr/sys returns 0.
- Read/write same register, same edge: read returns the old value (read-before-write). The next read returns the new value.
- Write: at an edge with write_en=1, the mode-mapped register takes write_value. No PC alignment or masking is applied; all 32 bits are stored.
- Bank selection at any edge uses the mode in CPSR before that edge's updates.
- SPSR restore:
  - Trigger: write_en=1, write_reg==15 and write_restore_from_SPSR=1 in an exception mode.
  - The R15 write and CPSR <= SPSR(current mode) occur on the same edge.
  - In usr/sys: R15 is still written, CPSR is unchanged.
  - write_restore_from_SPSR with write_reg!=15 or write_en=0 is ignored.
- CPSR write priority: an SPSR restore beats cpsr_write_en on the same edge. Otherwise cpsr_write_en loads all 32 bits.
- spsr_write_en:
  - In an exception mode, loads that mode's SPSR.
  - In usr/sys, ignored.
  - On an edge with a simultaneous mode change, the pre-edge mode's SPSR is written.
- Mode switch: the new banking is visible to requests on the edge after the CPSR update. Banked contents are preserved across switches.
- No handshake and no stall: every request is accepted in the cycle it is presented.

Test Plan:
1. rst for 2 cycles -> mode=10011, cpsr_read (next cycle) = 0x000000D3, read R0..R15 all 0.
2. write R15=0x00001000; next edge read R15 -> read_value=0x00001000. Same edge write R15=0x1004 and read R15 -> old 0x1000, following read 0x1004.
3. Banking:
   - Stimulus: in svc write R14=0x2004; cpsr_write 0x10 (usr); read R14; write R14=0xAAAA; cpsr_write 0x13.
   - Response: usr R14 read = 0; final svc R14 read = 0x2004.
4. FIQ banking: cpsr=0x11, write R8=0x55; cpsr=0x10 -> R8 reads 0. Back in fiq -> 0x55. R0 is shared across both.
5. Restore:
   - Stimulus: in irq, spsr_write 0x60000010; write R15=0x3000 with write_restore_from_SPSR=1 and cpsr_write_en=1 (0x1F) on the same edge.
   - Response: CPSR=0x60000010, mode=10000, R15=0x3000.
   - Repeat in usr: CPSR unchanged.
6. rst asserted on the same edge as write_en (R3=0xFF) -> R3 reads 0, CPSR=0xD3.

Source files
------------

// File: rtl/arm_regbank.sv
// ARM7 register bank: mode-banked GPRs, CPSR and per-mode SPSRs behind one read port,
// one write port (with SPSR restore on R15 writes) and CPSR/SPSR access ports.
module arm_regbank #(
  parameter logic [31:0] RESET_CPSR = 32'h000000D3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic [3:0]  read_reg,
  output logic [31:0] read_value,
  input  logic        write_en,
  input  logic [3:0]  write_reg,
  input  logic [31:0] write_value,
  input  logic        write_restore_from_SPSR,
  input  logic        cpsr_read_en,
  output logic [31:0] cpsr_read_value,
  input  logic        cpsr_write_en,
  input  logic [31:0] cpsr_write_value,
  input  logic        spsr_read_en,
  output logic [31:0] spsr_read_value,
  input  logic        spsr_write_en,
  input  logic [31:0] spsr_write_value,
  output logic [4:0]  mode
);

  // Bank 0 is usr/sys (and any undefined encoding); it has no SPSR, so spsr_q[0] stays 0.
  function automatic logic [2:0] bank_of(input logic [4:0] m);
    case (m)
      5'b10001: bank_of = 3'd1;
      5'b10010: bank_of = 3'd2;
      5'b10011: bank_of = 3'd3;
      5'b10111: bank_of = 3'd4;
      5'b11011: bank_of = 3'd5;
      default:  bank_of = 3'd0;
    endcase
  endfunction

  logic [31:0] lo_q[8],     lo_d[8];
  logic [31:0] usr_hi_q[5], usr_hi_d[5];
  logic [31:0] fiq_hi_q[5], fiq_hi_d[5];
  logic [31:0] r13_q[6],    r13_d[6];
  logic [31:0] r14_q[6],    r14_d[6];
  logic [31:0] spsr_q[6],   spsr_d[6];
  logic [31:0] r15_q, r15_d;
  logic [31:0] cpsr_q, cpsr_d;
  logic [31:0] read_value_q, read_value_d;
  logic [31:0] cpsr_read_value_q, cpsr_read_value_d;
  logic [31:0] spsr_read_value_q, spsr_read_value_d;

  logic [2:0]  bank;
  logic        is_fiq;
  logic [2:0]  rd_hi_idx, wr_hi_idx;
  logic [31:0] rd_data;
  logic        restore;

  assign bank      = bank_of(cpsr_q[4:0]);
  assign is_fiq    = (bank == 3'd1);
  assign rd_hi_idx = 3'(read_reg - 4'd8);
  assign wr_hi_idx = 3'(write_reg - 4'd8);
  assign restore   = write_en && (write_reg == 4'd15) && write_restore_from_SPSR &&
                     (bank != 3'd0);

  always_comb begin
    if (read_reg < 4'd8) begin
      rd_data = lo_q[read_reg[2:0]];
    end else if (read_reg < 4'd13) begin
      rd_data = is_fiq ? fiq_hi_q[rd_hi_idx] : usr_hi_q[rd_hi_idx];
    end else if (read_reg == 4'd13) begin
      rd_data = r13_q[bank];
    end else if (read_reg == 4'd14) begin
      rd_data = r14_q[bank];
    end else begin
      rd_data = r15_q;
    end
  end

  always_comb begin
    read_value_d      = read_en      ? rd_data      : read_value_q;
    cpsr_read_value_d = cpsr_read_en ? cpsr_q       : cpsr_read_value_q;
    spsr_read_value_d = spsr_read_en ? spsr_q[bank] : spsr_read_value_q;

    lo_d     = lo_q;
    usr_hi_d = usr_hi_q;
    fiq_hi_d = fiq_hi_q;
    r13_d    = r13_q;
    r14_d    = r14_q;
    r15_d    = r15_q;
    spsr_d   = spsr_q;

    if (write_en) begin
      if (write_reg < 4'd8) begin
        lo_d[write_reg[2:0]] = write_value;
      end else if (write_reg < 4'd13) begin
        if (is_fiq) fiq_hi_d[wr_hi_idx] = write_value;
        else        usr_hi_d[wr_hi_idx] = write_value;
      end else if (write_reg == 4'd13) begin
        r13_d[bank] = write_value;
      end else if (write_reg == 4'd14) begin
        r14_d[bank] = write_value;
      end else begin
        r15_d = write_value;
      end
    end

    // Restore reads the pre-edge SPSR, so a same-edge spsr_write does not leak into CPSR.
    if (restore)            cpsr_d = spsr_q[bank];
    else if (cpsr_write_en) cpsr_d = cpsr_write_value;
    else                    cpsr_d = cpsr_q;

    if (spsr_write_en && (bank != 3'd0)) spsr_d[bank] = spsr_write_value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q              <= '{default: '0};
      usr_hi_q          <= '{default: '0};
      fiq_hi_q          <= '{default: '0};
      r13_q             <= '{default: '0};
      r14_q             <= '{default: '0};
      spsr_q            <= '{default: '0};
      r15_q             <= '0;
      cpsr_q            <= RESET_CPSR;
      read_value_q      <= '0;
      cpsr_read_value_q <= '0;
      spsr_read_value_q <= '0;
    end else begin
      lo_q              <= lo_d;
      usr_hi_q          <= usr_hi_d;
      fiq_hi_q          <= fiq_hi_d;
      r13_q             <= r13_d;
      r14_q             <= r14_d;
      spsr_q            <= spsr_d;
      r15_q             <= r15_d;
      cpsr_q            <= cpsr_d;
      read_value_q      <= read_value_d;
      cpsr_read_value_q <= cpsr_read_value_d;
      spsr_read_value_q <= spsr_read_value_d;
    end
  end

  assign read_value      = read_value_q;
  assign cpsr_read_value = cpsr_read_value_q;
  assign spsr_read_value = spsr_read_value_q;
  assign mode            = cpsr_q[4:0];

endmodule

// File: tb/tb_arm_regbank.sv
// Directed plus random bench for arm_regbank against a key-addressed storage model.
module tb_arm_regbank;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en;
  logic [3:0]  read_reg;
  logic [31:0] read_value;
  logic        write_en;
  logic [3:0]  write_reg;
  logic [31:0] write_value;
  logic        write_restore_from_SPSR;
  logic        cpsr_read_en;
  logic [31:0] cpsr_read_value;
  logic        cpsr_write_en;
  logic [31:0] cpsr_write_value;
  logic        spsr_read_en;
  logic [31:0] spsr_read_value;
  logic        spsr_write_en;
  logic [31:0] spsr_write_value;
  logic [4:0]  mode;

  arm_regbank #(.RESET_CPSR(32'h000000D3)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .read_en                 (read_en),
    .read_reg                (read_reg),
    .read_value              (read_value),
    .write_en                (write_en),
    .write_reg               (write_reg),
    .write_value             (write_value),
    .write_restore_from_SPSR (write_restore_from_SPSR),
    .cpsr_read_en            (cpsr_read_en),
    .cpsr_read_value         (cpsr_read_value),
    .cpsr_write_en           (cpsr_write_en),
    .cpsr_write_value        (cpsr_write_value),
    .spsr_read_en            (spsr_read_en),
    .spsr_read_value         (spsr_read_value),
    .spsr_write_en           (spsr_write_en),
    .spsr_write_value        (spsr_write_value),
    .mode                    (mode)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: storage addressed by a "physical key" derived from the ARM banking rules.
  logic [31:0] phys[128];
  logic [31:0] spsr_m[32];
  logic [31:0] cpsr_m;
  logic [31:0] exp_rd, exp_c, exp_s;

  function automatic bit is_exc(input logic [4:0] m);
    return (m == 5'h11) || (m == 5'h12) || (m == 5'h13) || (m == 5'h17) || (m == 5'h1B);
  endfunction

  function automatic int key(input logic [4:0] m, input logic [3:0] r);
    if (r < 8 || r == 15) return int'(r);
    if (r < 13) return (m == 5'h11) ? 32 + int'(r) : int'(r);
    return 64 + 2 * (is_exc(m) ? int'(m) : 16) + (int'(r) - 13);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rst = 0; read_en = 0; read_reg = 0; write_en = 0; write_reg = 0; write_value = 0;
    write_restore_from_SPSR = 0; cpsr_read_en = 0; cpsr_write_en = 0; cpsr_write_value = 0;
    spsr_read_en = 0; spsr_write_en = 0; spsr_write_value = 0;
  endtask

  // Advance the model with the current inputs, clock the DUT, compare all outputs.
  task automatic tick();
    logic [4:0]  m;
    logic [31:0] new_cpsr;
    if (rst) begin
      for (int i = 0; i < 128; i++) phys[i] = '0;
      for (int i = 0; i < 32; i++) spsr_m[i] = '0;
      cpsr_m = 32'hD3; exp_rd = '0; exp_c = '0; exp_s = '0;
    end else begin
      m = cpsr_m[4:0];
      if (read_en)      exp_rd = phys[key(m, read_reg)];
      if (cpsr_read_en) exp_c  = cpsr_m;
      if (spsr_read_en) exp_s  = is_exc(m) ? spsr_m[m] : 32'h0;
      new_cpsr = cpsr_m;
      if (write_en) phys[key(m, write_reg)] = write_value;
      if (write_en && write_reg == 15 && write_restore_from_SPSR && is_exc(m))
        new_cpsr = spsr_m[m];
      else if (cpsr_write_en)
        new_cpsr = cpsr_write_value;
      if (spsr_write_en && is_exc(m)) spsr_m[m] = spsr_write_value;
      cpsr_m = new_cpsr;
    end
    @(posedge clk);
    #1;
    check("read_value", read_value, exp_rd);
    check("cpsr_read_value", cpsr_read_value, exp_c);
    check("spsr_read_value", spsr_read_value, exp_s);
    check("mode", {27'd0, mode}, {27'd0, cpsr_m[4:0]});
  endtask

  task automatic set_cpsr(input logic [31:0] v);
    clr(); cpsr_write_en = 1; cpsr_write_value = v; tick();
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] v);
    clr(); write_en = 1; write_reg = r; write_value = v; tick();
  endtask

  task automatic rd(input logic [3:0] r, input logic [31:0] exp, input string tag);
    clr(); read_en = 1; read_reg = r; tick();
    check(tag, read_value, exp);
  endtask

  logic [4:0] modes[8] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F, 5'h05};

  initial begin
    logic [31:0] rv;
    clr();
    // Reset and initial state
    rst = 1; tick(); tick();
    clr();
    check("reset_mode", {27'd0, mode}, 32'h13);
    cpsr_read_en = 1; tick();
    check("reset_cpsr", cpsr_read_value, 32'hD3);
    for (int r = 0; r < 16; r++) rd(4'(r), 32'h0, "reset_gpr");

    // R15 write/read and read-before-write
    wr(4'd15, 32'h1000);
    rd(4'd15, 32'h1000, "r15_write");
    clr(); write_en = 1; write_reg = 15; write_value = 32'h1004; read_en = 1; read_reg = 15;
    tick();
    check("r15_rbw_old", read_value, 32'h1000);
    rd(4'd15, 32'h1004, "r15_rbw_new");

    // svc/usr R14 banking
    wr(4'd14, 32'h2004);
    set_cpsr(32'h10);
    rd(4'd14, 32'h0, "usr_r14");
    wr(4'd14, 32'hAAAA);
    set_cpsr(32'h13);
    rd(4'd14, 32'h2004, "svc_r14");

    // FIQ R8 banking, R0 shared
    set_cpsr(32'h11);
    wr(4'd8, 32'h55);
    wr(4'd0, 32'h77);
    set_cpsr(32'h10);
    rd(4'd8, 32'h0, "usr_r8");
    rd(4'd0, 32'h77, "usr_r0_shared");
    set_cpsr(32'h11);
    rd(4'd8, 32'h55, "fiq_r8");

    // SPSR restore beats cpsr_write_en
    set_cpsr(32'h12);
    clr(); spsr_write_en = 1; spsr_write_value = 32'h60000010; tick();
    clr(); write_en = 1; write_reg = 15; write_value = 32'h3000; write_restore_from_SPSR = 1;
    cpsr_write_en = 1; cpsr_write_value = 32'h1F; tick();
    check("restore_mode", {27'd0, mode}, 32'h10);
    clr(); cpsr_read_en = 1; tick();
    check("restore_cpsr", cpsr_read_value, 32'h60000010);
    rd(4'd15, 32'h3000, "restore_r15");
    clr(); write_en = 1; write_reg = 15; write_value = 32'h3100; write_restore_from_SPSR = 1;
    tick();
    clr(); cpsr_read_en = 1; spsr_read_en = 1; tick();
    check("usr_restore_cpsr", cpsr_read_value, 32'h60000010);
    check("usr_spsr_read", spsr_read_value, 32'h0);
    rd(4'd15, 32'h3100, "usr_restore_r15");

    // Reset wins over a same-edge write
    clr(); rst = 1; write_en = 1; write_reg = 3; write_value = 32'hFF; tick();
    clr(); read_en = 1; read_reg = 3; cpsr_read_en = 1; tick();
    check("rst_r3", read_value, 32'h0);
    check("rst_cpsr", cpsr_read_value, 32'hD3);

    // Random traffic checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      clr();
      rst                     = ($urandom_range(0, 99) == 0);
      read_en                 = $urandom_range(0, 3) != 0;
      read_reg                = 4'($urandom_range(0, 15));
      write_en                = $urandom_range(0, 1) == 1;
      write_reg               = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      write_value             = $urandom();
      write_restore_from_SPSR = $urandom_range(0, 1) == 1;
      cpsr_read_en            = $urandom_range(0, 1) == 1;
      cpsr_write_en           = $urandom_range(0, 9) == 0;
      rv                      = $urandom();
      cpsr_write_value        = {rv[31:5], modes[$urandom_range(0, 7)]};
      spsr_read_en            = $urandom_range(0, 1) == 1;
      spsr_write_en           = $urandom_range(0, 3) == 0;
      spsr_write_value        = $urandom();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
